lap_stopwatch_core: RTL and testbench
=====================================

// Module: lap_stopwatch_core
// PURPOSE
//  Parametrised up/down stopwatch/timer core: MM:SS:CC counter, internal tick prescaler, lap ring buffer.
//  Sits between the button command controller (single-cycle command pulses) and the FND/buzzer controllers.
//  Adds a countdown mode with preset and expiry pulse, saturating overflow and lap capture/readback.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency
//  TICK_HZ    100          count rate (centiseconds); DIV = CLK_HZ/TICK_HZ, DIV >= 2
//  MAX_MIN    99           highest minute value, <= 127
//  LAP_DEPTH  4            lap entries, power of 2, >= 2; LAP_AW = $clog2(LAP_DEPTH) (localparam)
// PORTS
//  clk           in   1         system clock
//  reset         in   1         synchronous, active-high
//  cmd_run_stop  in   1         1-cycle pulse: start/pause/resume/acknowledge
//  cmd_clear     in   1         1-cycle pulse: return to IDLE, reload count, empty laps
//  cmd_lap       in   1         1-cycle pulse: capture current time (RUN only)
//  cmd_mode      in   1         1-cycle pulse: toggle up/down (IDLE only)
//  preset_min    in   7         countdown preset minutes (clamped to MAX_MIN)
//  preset_sec    in   6         countdown preset seconds (clamped to 59)
//  lap_rd_idx    in   LAP_AW    0 = most recent lap
//  min_count     out  7         minutes
//  sec_count     out  6         seconds 0..59
//  cs_count      out  7         centiseconds 0..99
//  running       out  1         1 in RUN
//  mode_down     out  1         1 = countdown
//  expired       out  1         1-cycle pulse on countdown reaching 00:00:00 (buzzer trigger)
//  overflow      out  1         sticky: up-count saturated; cleared by cmd_clear
//  lap_cnt       out  LAP_AW+1  valid lap entries, saturates at LAP_DEPTH
//  lap_rd_data   out  20        {min7,sec6,cs7} of entry lap_rd_idx, registered, 1-cycle latency
// BEHAVIOUR
//  Reset: state IDLE, all outputs and counters 0, mode_down 0, lap buffer empty, prescaler 0.
//  FSM IDLE/RUN/PAUSE/DONE:
//   IDLE  --run_stop--> RUN (ignored if mode_down and count == 0); cmd_mode toggles mode, loads 0 (up) or preset (down).
//   RUN   --run_stop--> PAUSE; --terminal tick--> DONE.
//   PAUSE --run_stop--> RUN.  DONE --run_stop--> IDLE (reload as cmd_clear).
//   any   --cmd_clear--> IDLE; count = 0 (up) / clamped preset (down); laps emptied; overflow 0.
//  Priority: cmd_clear > cmd_run_stop > cmd_lap; cmd_mode ignored outside IDLE.
//  Prescaler: counts only in RUN, holds in PAUSE, zeroed in IDLE/DONE; tick on cycle prescaler == DIV-1.
//  Up tick: cs 99->0 carries sec, sec 59->0 carries min. At MAX_MIN:59:99 the tick holds value, sets overflow, -> DONE.
//  Down tick: borrow chain mirrored; tick reaching 00:00:00 -> DONE, expired=1 that same registered cycle only.
//  Counts update one cycle after the tick cycle; running follows state with no extra latency.
//  Lap: accepted in RUN only; captures count as registered before a coincident tick; circular write,
//   oldest overwritten when full, lap_cnt saturates. Entries beyond lap_cnt read 0.
//  Reset mid-RUN: same as power-on reset; no expired pulse emitted.
// CONFIGURATION
//  LAP_MEMORY_EN defined: lap buffer built as above.
//  LAP_MEMORY_EN undefined: no storage; cmd_lap ignored; lap_cnt and lap_rd_data tied 0; port list unchanged.
// STRUCTURE
//  Package lap_stopwatch_pkg: state enum (IDLE,RUN,PAUSE,DONE), CS_MAX=99, SEC_MAX=59, time field widths,
//   packed lap record {min,sec,cs} of 20 bits.
//  Sub-module lap_stopwatch_lap_buffer: ring write pointer, count, registered read; instantiated under LAP_MEMORY_EN.
// TESTING  (CLK_HZ=10, TICK_HZ=1 -> DIV=10, LAP_DEPTH=4)
//  Up: run_stop, 1500 clk -> 00:01:50, running=1; run_stop -> running=0, value frozen 50 clk; run_stop resumes.
//  Overflow: MAX_MIN=1, run to 01:59:99, next tick -> holds 01:59:99, overflow=1, DONE; cmd_clear -> 00:00:00, overflow=0.
//  Down: cmd_mode, preset 0:01, run_stop; after 100 ticks -> 00:00:00, expired high exactly 1 clk; run_stop -> IDLE, 00:01:00.
//  Laps: 5 laps at ticks 10,20,30,40,50 -> lap_cnt=4, idx0=00:00:50, idx3=00:00:20; lap in PAUSE ignored.
//  Simultaneous cmd_clear+cmd_run_stop+cmd_lap in RUN -> IDLE, 00:00:00, lap_cnt=0; reset mid-RUN -> all zero, no expired.
//  Build without LAP_MEMORY_EN: 3 cmd_lap in RUN -> lap_cnt=0, lap_rd_data=0, counting unaffected.

Source files
------------

// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch core.
//
// Contents:
//   sw_state_t     : controller states IDLE / RUN / PAUSE / DONE
//   CS_MAX, SEC_MAX: wrap points of the centisecond and second fields
//   MIN_W/SEC_W/CS_W: time field widths
//   lap_rec_t      : packed {min, sec, cs} time record, 20 bits; it is used both for
//                    the live count and for lap entries
//   time_is_zero() : true for 00:00:00
package lap_stopwatch_pkg;

    localparam int MIN_W     = 7;
    localparam int SEC_W     = 6;
    localparam int CS_W      = 7;
    localparam int LAP_REC_W = MIN_W + SEC_W + CS_W;

    localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_t;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [CS_W-1:0]  cs;
    } lap_rec_t;

    function automatic logic time_is_zero(input lap_rec_t t);
        return (t == '0);
    endfunction

endpackage

// File: rtl/lap_stopwatch_lap_buffer.sv
// Circular lap store for the stopwatch core.
//
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   clear           : empties the buffer (pointer and count back to 0)
//   wr_en, wr_data  : capture one lap record; the oldest entry is overwritten when full
//   rd_idx          : 0 = most recent entry
//   cnt             : number of valid entries, saturates at LAP_DEPTH
//   rd_data         : registered read of entry rd_idx; 0 when rd_idx >= cnt
module lap_stopwatch_lap_buffer
    import lap_stopwatch_pkg::*;
#(
    parameter  int LAP_DEPTH = 4,
    localparam int LAP_AW    = $clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  lap_rec_t          wr_data,
    input  logic [LAP_AW-1:0] rd_idx,
    output logic [LAP_AW:0]   cnt,
    output lap_rec_t          rd_data
);

    lap_rec_t          mem [LAP_DEPTH];
    logic [LAP_AW-1:0] wr_ptr;
    logic [LAP_AW-1:0] rd_addr;

    // Depth is a power of two, so the pointer arithmetic wraps for free.
    assign rd_addr = wr_ptr - LAP_AW'(1) - rd_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            cnt     <= '0;
            rd_data <= '0;
        end else begin
            rd_data <= ({1'b0, rd_idx} < cnt) ? mem[rd_addr] : '0;
            if (clear) begin
                wr_ptr <= '0;
                cnt    <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + LAP_AW'(1);
                if (cnt != (LAP_AW+1)'(LAP_DEPTH)) begin
                    cnt <= cnt + (LAP_AW+1)'(1);
                end
            end
        end
    end

    // Storage needs no reset: entries at or beyond cnt are never returned.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/lap_stopwatch_core.sv
// Up/down MM:SS:CC stopwatch/timer core with internal tick prescaler,
// saturating overflow, countdown expiry pulse and optional lap ring buffer.
//
// Build option: define LAP_MEMORY_EN to build the lap buffer. Without it the
// buffer is absent, cmd_lap has no effect and lap_cnt / lap_rd_data read 0.
//
// Ports:
//   clk, reset               : system clock, synchronous active-high reset
//   cmd_run_stop             : start / pause / resume / acknowledge DONE
//   cmd_clear                : back to IDLE, reload count, empty laps, clear overflow
//   cmd_lap                  : capture current time (RUN only)
//   cmd_mode                 : toggle up/down (IDLE only)
//   preset_min, preset_sec   : countdown preset, clamped to MAX_MIN / 59
//   lap_rd_idx               : lap read index, 0 = most recent
//   min_count/sec_count/cs_count : current time
//   running, mode_down       : status
//   expired                  : one-cycle pulse when a countdown reaches 00:00:00
//   overflow                 : sticky, set when up-count saturates
//   lap_cnt, lap_rd_data     : lap entry count and registered read data {min,sec,cs}
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | stopped, count loaded (0 or preset), prescaler zeroed
// RUN     | prescaler counting, count advances on each tick
// PAUSE   | count and prescaler frozen
// DONE    | saturated (up) or expired (down); waits for run_stop/clear
module lap_stopwatch_core
    import lap_stopwatch_pkg::*;
#(
    parameter  int CLK_HZ    = 100_000_000,
    parameter  int TICK_HZ   = 100,
    parameter  int MAX_MIN   = 99,
    parameter  int LAP_DEPTH = 4,
    localparam int LAP_AW    = $clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_run_stop,
    input  logic              cmd_clear,
    input  logic              cmd_lap,
    input  logic              cmd_mode,
    input  logic [6:0]        preset_min,
    input  logic [5:0]        preset_sec,
    input  logic [LAP_AW-1:0] lap_rd_idx,
    output logic [6:0]        min_count,
    output logic [5:0]        sec_count,
    output logic [6:0]        cs_count,
    output logic              running,
    output logic              mode_down,
    output logic              expired,
    output logic              overflow,
    output logic [LAP_AW:0]   lap_cnt,
    output logic [19:0]       lap_rd_data
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam logic [MIN_W-1:0] MIN_LIM = MIN_W'(MAX_MIN);

    sw_state_t        state_q, state_d;
    lap_rec_t         time_q, time_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             exp_q, exp_d;
    logic             lap_wr;
    logic             reload;
    logic             tick;
    logic             up_at_max;
    logic             dn_hit;
    lap_rec_t         time_up, time_dn, preset_time;

    assign tick = (state_q == ST_RUN) && (presc_q == PRE_W'(DIV - 1));

    always_comb begin
        preset_time     = '0;
        preset_time.min = (preset_min > MIN_LIM) ? MIN_LIM : preset_min;
        preset_time.sec = (preset_sec > SEC_MAX) ? SEC_MAX : preset_sec;
    end

    always_comb begin
        time_up = time_q;
        if (time_q.cs != CS_MAX) begin
            time_up.cs = time_q.cs + 7'd1;
        end else begin
            time_up.cs = '0;
            if (time_q.sec != SEC_MAX) begin
                time_up.sec = time_q.sec + 6'd1;
            end else begin
                time_up.sec = '0;
                time_up.min = time_q.min + 7'd1;
            end
        end
    end

    assign up_at_max = (time_q.min == MIN_LIM) && (time_q.sec == SEC_MAX) &&
                       (time_q.cs == CS_MAX);

    // A countdown sitting at zero stays there rather than wrapping.
    always_comb begin
        time_dn = time_q;
        if (!time_is_zero(time_q)) begin
            if (time_q.cs != '0) begin
                time_dn.cs = time_q.cs - 7'd1;
            end else begin
                time_dn.cs = CS_MAX;
                if (time_q.sec != '0) begin
                    time_dn.sec = time_q.sec - 6'd1;
                end else begin
                    time_dn.sec = SEC_MAX;
                    time_dn.min = time_q.min - 7'd1;
                end
            end
        end
    end

    assign dn_hit = time_is_zero(time_dn);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        exp_d   = 1'b0;
        lap_wr  = 1'b0;
        reload  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (cmd_clear) begin
                    reload = 1'b1;
                end else if (cmd_run_stop) begin
                    if (!(mode_q && time_is_zero(time_q))) begin
                        state_d = ST_RUN;
                    end
                end else if (cmd_mode) begin
                    mode_d = ~mode_q;
                    time_d = mode_q ? lap_rec_t'('0) : preset_time;
                end
            end
            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + PRE_W'(1);
                if (cmd_clear) begin
                    reload  = 1'b1;
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else begin
                    if (tick) begin
                        if (mode_q) begin
                            time_d = time_dn;
                            if (dn_hit) begin
                                state_d = ST_DONE;
                                exp_d   = !time_is_zero(time_q);
                            end
                        end else if (up_at_max) begin
                            ovf_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            time_d = time_up;
                        end
                    end
                    // A terminal tick wins over a coincident pause request.
                    if (cmd_run_stop) begin
                        if (state_d == ST_RUN) begin
                            state_d = ST_PAUSE;
                        end
                    end else if (cmd_lap) begin
                        lap_wr = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (cmd_clear) begin
                    reload  = 1'b1;
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (cmd_run_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                presc_d = '0;
                if (cmd_clear || cmd_run_stop) begin
                    reload  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase
        if (reload) begin
            time_d = mode_q ? preset_time : lap_rec_t'('0);
            ovf_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            presc_q <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            presc_q <= presc_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            exp_q   <= exp_d;
        end
    end

    assign min_count = time_q.min;
    assign sec_count = time_q.sec;
    assign cs_count  = time_q.cs;
    assign running   = (state_q == ST_RUN);
    assign mode_down = mode_q;
    assign expired   = exp_q;
    assign overflow  = ovf_q;

`ifdef LAP_MEMORY_EN
    lap_rec_t lap_rd_rec;

    lap_stopwatch_lap_buffer #(
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (reload),
        .wr_en   (lap_wr),
        .wr_data (time_q),
        .rd_idx  (lap_rd_idx),
        .cnt     (lap_cnt),
        .rd_data (lap_rd_rec)
    );

    assign lap_rd_data = lap_rd_rec;
`else
    logic unused_lap;
    assign unused_lap  = ^{lap_wr, lap_rd_idx};
    assign lap_cnt     = '0;
    assign lap_rd_data = '0;
`endif

endmodule

// File: tb/tb_lap_stopwatch_core.sv
module tb_lap_stopwatch_core;

`ifdef LAP_MEMORY_EN
    localparam bit LAPS = 1'b1;
`else
    localparam bit LAPS = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t sb[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    // main instance: DIV = 10, MAX_MIN = 99
    logic       run_stop, clear, lap, mode;
    logic [6:0] pmin;
    logic [5:0] psec;
    logic [1:0] idx;
    logic [6:0] min_c;
    logic [5:0] sec_c;
    logic [6:0] cs_c;
    logic       running, mode_down, expired, overflow;
    logic [2:0] lap_cnt;
    logic [19:0] lap_data;
    // overflow instance: DIV = 2, MAX_MIN = 1
    logic       b_run_stop, b_clear, b_lap, b_mode;
    logic [6:0] b_pmin;
    logic [5:0] b_psec;
    logic [1:0] b_idx;
    logic [6:0] b_min_c;
    logic [5:0] b_sec_c;
    logic [6:0] b_cs_c;
    logic       b_running, b_mode_down, b_expired, b_overflow;
    logic [2:0] b_lap_cnt;
    logic [19:0] b_lap_data;

    lap_stopwatch_core #(.CLK_HZ(10), .TICK_HZ(1), .MAX_MIN(99), .LAP_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .cmd_run_stop(run_stop), .cmd_clear(clear),
        .cmd_lap(lap), .cmd_mode(mode), .preset_min(pmin), .preset_sec(psec),
        .lap_rd_idx(idx), .min_count(min_c), .sec_count(sec_c), .cs_count(cs_c),
        .running(running), .mode_down(mode_down), .expired(expired),
        .overflow(overflow), .lap_cnt(lap_cnt), .lap_rd_data(lap_data)
    );

    lap_stopwatch_core #(.CLK_HZ(2), .TICK_HZ(1), .MAX_MIN(1), .LAP_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .cmd_run_stop(b_run_stop), .cmd_clear(b_clear),
        .cmd_lap(b_lap), .cmd_mode(b_mode), .preset_min(b_pmin), .preset_sec(b_psec),
        .lap_rd_idx(b_idx), .min_count(b_min_c), .sec_count(b_sec_c), .cs_count(b_cs_c),
        .running(b_running), .mode_down(b_mode_down), .expired(b_expired),
        .overflow(b_overflow), .lap_cnt(b_lap_cnt), .lap_rd_data(b_lap_data)
    );

    function automatic logic [31:0] tv(input int m, input int s, input int c);
        return {12'd0, 7'(m), 6'(s), 7'(c)};
    endfunction

    function automatic logic [31:0] t0();
        return {12'd0, min_c, sec_c, cs_c};
    endfunction

    function automatic logic [31:0] t1();
        return {12'd0, b_min_c, b_sec_c, b_cs_c};
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit rs, input bit cl, input bit lp, input bit md);
        run_stop = rs; clear = cl; lap = lp; mode = md;
        @(negedge clk);
        run_stop = 1'b0; clear = 1'b0; lap = 1'b0; mode = 1'b0;
    endtask

    task automatic pulse_b(input bit rs, input bit cl);
        b_run_stop = rs; b_clear = cl;
        @(negedge clk);
        b_run_stop = 1'b0; b_clear = 1'b0;
    endtask

    task automatic read_lap(input int i, input string tag, input logic [31:0] v);
        idx = 2'(i);
        expect_val(tag, v);
        wait_clk(1);
        check({12'd0, lap_data});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic seen_exp;
        reset = 1'b1;
        run_stop = 0; clear = 0; lap = 0; mode = 0; pmin = 0; psec = 0; idx = 0;
        b_run_stop = 0; b_clear = 0; b_lap = 0; b_mode = 0; b_pmin = 0; b_psec = 0; b_idx = 0;
        wait_clk(3);
        reset = 1'b0;

        // reset state
        expect_val("rst_time", tv(0, 0, 0));
        expect_val("rst_flags", 0);
        expect_val("rst_lap_cnt", 0);
        check(t0());
        check({running, mode_down, expired, overflow});
        check(lap_cnt);

        // up count, pause, resume
        pulse(1, 0, 0, 0);
        expect_val("up_1m50", tv(0, 1, 50));
        expect_val("up_running", 1);
        wait_clk(1500);
        check(t0());
        check(running);
        pulse(1, 0, 0, 0);
        expect_val("pause_running", 0);
        check(running);
        expect_val("pause_frozen", tv(0, 1, 50));
        wait_clk(50);
        check(t0());
        pulse(1, 0, 0, 0);
        expect_val("resume_running", 1);
        check(running);
        expect_val("resume_two_ticks", tv(0, 1, 52));
        wait_clk(20);
        check(t0());

        pulse(0, 1, 0, 0);
        expect_val("clear_time", tv(0, 0, 0));
        expect_val("clear_running", 0);
        check(t0());
        check(running);

        // laps at 10,20,30,40,50 centiseconds
        pulse(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            wait_clk(k == 0 ? 100 : 99);
            pulse(0, 0, 1, 0);
        end
        expect_val("lap_time_unaffected", tv(0, 0, 50));
        expect_val("lap_cnt_full", LAPS ? 4 : 0);
        check(t0());
        check(lap_cnt);
        read_lap(0, "lap_idx0", LAPS ? tv(0, 0, 50) : 0);
        read_lap(3, "lap_idx3", LAPS ? tv(0, 0, 20) : 0);
        read_lap(1, "lap_idx1", LAPS ? tv(0, 0, 40) : 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        expect_val("lap_in_pause_cnt", LAPS ? 4 : 0);
        check(lap_cnt);
        read_lap(0, "lap_in_pause_idx0", LAPS ? tv(0, 0, 50) : 0);

        // simultaneous clear + run_stop + lap in RUN
        pulse(1, 0, 0, 0);
        wait_clk(3);
        pulse(1, 1, 1, 0);
        expect_val("simul_running", 0);
        expect_val("simul_time", tv(0, 0, 0));
        expect_val("simul_lap_cnt", 0);
        check(running);
        check(t0());
        check(lap_cnt);
        read_lap(0, "simul_idx0_empty", 0);

        // countdown: zero preset cannot start
        pmin = 0; psec = 0;
        pulse(0, 0, 0, 1);
        expect_val("zero_preset_mode", 1);
        check(mode_down);
        pulse(1, 0, 0, 0);
        expect_val("zero_preset_no_run", 0);
        check(running);
        pulse(0, 0, 0, 1);
        // preset clamping
        pmin = 7'd120; psec = 6'd63;
        pulse(0, 0, 0, 1);
        expect_val("clamp_preset", tv(99, 59, 0));
        check(t0());
        pulse(0, 0, 0, 1);
        expect_val("mode_back_up", tv(0, 0, 0));
        check(t0());
        pmin = 0; psec = 1;
        pulse(0, 0, 0, 1);
        expect_val("down_loaded", tv(0, 1, 0));
        check(t0());

        pulse(1, 0, 0, 0);
        wait_clk(5);
        pulse(0, 0, 0, 1);
        expect_val("mode_ignored_in_run", 1);
        check(mode_down);
        wait_clk(993);
        expect_val("down_last_cs", tv(0, 0, 1));
        expect_val("down_no_exp_yet", 0);
        check(t0());
        check(expired);
        wait_clk(1);
        expect_val("down_zero", tv(0, 0, 0));
        expect_val("down_expired", 1);
        expect_val("down_done", 0);
        check(t0());
        check(expired);
        check(running);
        wait_clk(1);
        expect_val("expired_one_cycle", 0);
        check(expired);
        pulse(1, 0, 0, 0);
        expect_val("done_ack_reload", tv(0, 1, 0));
        expect_val("done_ack_flags", 4'b0100);
        check(t0());
        check({running, mode_down, expired, overflow});

        // reset mid-RUN near expiry
        pulse(1, 0, 0, 0);
        wait_clk(995);
        reset = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        expect_val("midrun_rst_time", tv(0, 0, 0));
        expect_val("midrun_rst_flags", 0);
        check(t0());
        check({running, mode_down, expired, overflow});
        seen_exp = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_exp = seen_exp | expired;
        end
        expect_val("midrun_rst_no_expired", 0);
        check(seen_exp);

        // overflow instance
        pulse_b(1, 0);
        expect_val("ovf_at_max", tv(1, 59, 99));
        expect_val("ovf_not_yet", 0);
        expect_val("ovf_running", 1);
        wait_clk(23998);
        check(t1());
        check(b_overflow);
        check(b_running);
        wait_clk(2);
        expect_val("ovf_hold", tv(1, 59, 99));
        expect_val("ovf_set", 1);
        expect_val("ovf_done", 0);
        expect_val("ovf_no_expired", 0);
        check(t1());
        check(b_overflow);
        check(b_running);
        check(b_expired);
        expect_val("ovf_done_hold", tv(1, 59, 99));
        wait_clk(5);
        check(t1());
        pulse_b(0, 1);
        expect_val("ovf_clear_time", tv(0, 0, 0));
        expect_val("ovf_clear_flag", 0);
        expect_val("ovf_clear_misc", 0);
        check(t1());
        check(b_overflow);
        check({b_mode_down, b_lap_cnt, b_lap_data});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
